uart_tx_arbiter: RTL

//   Shares the single UART transmitter between NUM_REQ byte sources with round-robin fairness.

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that lets NUM_REQ byte producers share one UART
// transmitter. The transmitter has no busy or done output, so this block
// times each frame itself, then holds off for an optional inter-frame gap.
// The transmitter sees a one-cycle start pulse and a byte that is held
// stable from the grant until the next grant.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FRAME_CLKS = 10416,
    parameter int GAP_CLKS   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int CNT_MAX = (FRAME_CLKS > GAP_CLKS) ? FRAME_CLKS : GAP_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counter reload values; the gap load is only used when a gap exists
    localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CLKS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CLKS > 0) ? (GAP_CLKS - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  cnt;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic [7:0]        pick_data;

    // Rotating-priority search: first valid requester starting at rr_ptr
    always_comb begin
        logic [ID_W:0] cand;
        int            ci;
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_data  = 8'h00;
        cand       = '0;
        ci         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            ci = int'(cand);
            if (!pick_found && req_valid[ci]) begin
                pick_found = 1'b1;
                pick_idx   = cand[ID_W-1:0];
                pick_data  = req_data[8*ci +: 8];
            end
        end
    end

    // Accept is offered only in IDLE and never while reset is held
    assign req_ready = (state == IDLE && !rst && pick_found)
                       ? (NUM_REQ'(1) << pick_idx) : '0;

    // Control FSM: grant, start pulse, frame timing, optional gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            grant_id <= '0;
            cnt      <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        tx_data  <= pick_data;
                        grant_id <= pick_idx;
                        rr_ptr   <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    cnt   <= FRAME_LOAD;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (GAP_CLKS > 0) begin
                            cnt   <= GAP_LOAD;
                            state <= GAP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
